// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register.
// Holds the decoded instruction for one cycle. Detects load-use hazards,
// which stall ID/IF and insert one EXE bubble. Applies the forwarding
// unit's selects to build the EXE operands. A redirect that arrives during
// a global freeze is remembered until the pipeline can move again.
module id_exe_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned FWD_BITS = 2,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                id_valid_i,
  input  logic [REG_BITS-1:0] id_rs1_addr_i,
  input  logic [REG_BITS-1:0] id_rs2_addr_i,
  input  logic                id_use_rs1_i,
  input  logic                id_use_rs2_i,
  input  logic [XLEN-1:0]     id_rs1_data_i,
  input  logic [XLEN-1:0]     id_rs2_data_i,
  input  logic [XLEN-1:0]     id_imm_i,
  input  logic [REG_BITS-1:0] id_rd_addr_i,
  input  logic                id_reg_wr_i,
  input  logic                id_mem_rd_i,
  input  logic                stall_ext_i,
  input  logic                flush_i,
  input  logic [FWD_BITS-1:0] forward_rs1_i,
  input  logic [FWD_BITS-1:0] forward_rs2_i,
  input  logic [XLEN-1:0]     mem_fwd_data_i,
  input  logic                wb_reg_wr_i,
  input  logic [REG_BITS-1:0] wb_rd_addr_i,
  input  logic [XLEN-1:0]     wb_rd_data_i,
  output logic                exe_valid_o,
  output logic [REG_BITS-1:0] exe_rs1_addr_o,
  output logic [REG_BITS-1:0] exe_rs2_addr_o,
  output logic [REG_BITS-1:0] exe_rd_addr_o,
  output logic                exe_reg_wr_o,
  output logic                exe_mem_rd_o,
  output logic [XLEN-1:0]     exe_op1_o,
  output logic [XLEN-1:0]     exe_op2_o,
  output logic [XLEN-1:0]     exe_imm_o,
  output logic                id_stall_o,
  output logic [CNT_BITS-1:0] lu_stall_cnt_o
);

  logic            flush_pend;
  logic            flush_eff;
  logic            lu;
  logic            rs1_hit;
  logic            rs2_hit;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] rs1_capture;
  logic [XLEN-1:0] rs2_capture;

  // Hazard detection: a load in EXE whose rd (not x0) is read by ID.
  always_comb begin
    rs1_hit    = id_use_rs1_i && (id_rs1_addr_i == exe_rd_addr_o);
    rs2_hit    = id_use_rs2_i && (id_rs2_addr_i == exe_rd_addr_o);
    lu         = exe_valid_o && exe_mem_rd_o && (exe_rd_addr_o != '0) &&
                 id_valid_i && (rs1_hit || rs2_hit);
    flush_eff  = flush_i || flush_pend;
    id_stall_o = lu && !stall_ext_i && !flush_eff;
  end

  // WB bypass: a register written this cycle is read from the write port.
  always_comb begin
    rs1_capture = id_rs1_data_i;
    rs2_capture = id_rs2_data_i;
    if (wb_reg_wr_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == id_rs1_addr_i))
      rs1_capture = wb_rd_data_i;
    if (wb_reg_wr_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == id_rs2_addr_i))
      rs2_capture = wb_rd_data_i;
  end

  // Control registers: freeze holds, flush or load-use bubbles, else load ID.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      exe_valid_o    <= 1'b0;
      exe_rs1_addr_o <= '0;
      exe_rs2_addr_o <= '0;
      exe_rd_addr_o  <= '0;
      exe_reg_wr_o   <= 1'b0;
      exe_mem_rd_o   <= 1'b0;
    end else if (stall_ext_i) begin
      exe_valid_o    <= exe_valid_o;
    end else if (flush_eff || lu) begin
      exe_valid_o    <= 1'b0;
      exe_rs1_addr_o <= '0;
      exe_rs2_addr_o <= '0;
      exe_rd_addr_o  <= '0;
      exe_reg_wr_o   <= 1'b0;
      exe_mem_rd_o   <= 1'b0;
    end else begin
      exe_valid_o    <= id_valid_i;
      exe_rs1_addr_o <= id_rs1_addr_i;
      exe_rs2_addr_o <= id_rs2_addr_i;
      exe_rd_addr_o  <= id_rd_addr_i;
      exe_reg_wr_o   <= id_reg_wr_i;
      exe_mem_rd_o   <= id_mem_rd_i;
    end
  end

  // Data registers: contents of a bubble are don't-care, so capture whenever not frozen.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      exe_imm_o  <= '0;
    end else if (!stall_ext_i) begin
      rs1_data_q <= rs1_capture;
      rs2_data_q <= rs2_capture;
      exe_imm_o  <= id_imm_i;
    end
  end

  // Remember a redirect seen during a freeze until the first free edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      flush_pend <= 1'b0;
    else if (stall_ext_i)
      flush_pend <= flush_pend || flush_i;
    else
      flush_pend <= 1'b0;
  end

  // Count load-use stall cycles, saturating at all-ones.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      lu_stall_cnt_o <= '0;
    else if (id_stall_o && (lu_stall_cnt_o != '1))
      lu_stall_cnt_o <= lu_stall_cnt_o + 1'b1;
  end

  // Operand mux: 1 = MEM result, 2 = WB result, 0/3 = registered data.
  always_comb begin
    case (forward_rs1_i)
      FWD_BITS'(1): exe_op1_o = mem_fwd_data_i;
      FWD_BITS'(2): exe_op1_o = wb_rd_data_i;
      default:      exe_op1_o = rs1_data_q;
    endcase
    case (forward_rs2_i)
      FWD_BITS'(1): exe_op2_o = mem_fwd_data_i;
      FWD_BITS'(2): exe_op2_o = wb_rd_data_i;
      default:      exe_op2_o = rs2_data_q;
    endcase
  end

endmodule

// File: tb/tb_id_exe_stage.sv
// Testbench for id_exe_stage.
// Expected EXE contents are queued when an instruction is presented to ID
// and checked one edge later, when that instruction should sit in EXE.
module tb_id_exe_stage;

  localparam int CNT_BITS = 4;

  typedef struct {
    string       name;
    logic        valid;
    logic [4:0]  rd;
    logic        mem_rd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  logic [CNT_BITS-1:0] exp_cnt = '0;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        id_valid_i = 1'b0;
  logic [4:0]  id_rs1_addr_i = '0, id_rs2_addr_i = '0, id_rd_addr_i = '0;
  logic        id_use_rs1_i = 1'b0, id_use_rs2_i = 1'b0;
  logic [31:0] id_rs1_data_i = '0, id_rs2_data_i = '0, id_imm_i = '0;
  logic        id_reg_wr_i = 1'b0, id_mem_rd_i = 1'b0;
  logic        stall_ext_i = 1'b0, flush_i = 1'b0;
  logic [1:0]  forward_rs1_i = '0, forward_rs2_i = '0;
  logic [31:0] mem_fwd_data_i = '0;
  logic        wb_reg_wr_i = 1'b0;
  logic [4:0]  wb_rd_addr_i = '0;
  logic [31:0] wb_rd_data_i = '0;
  logic        exe_valid_o;
  logic [4:0]  exe_rs1_addr_o, exe_rs2_addr_o, exe_rd_addr_o;
  logic        exe_reg_wr_o, exe_mem_rd_o;
  logic [31:0] exe_op1_o, exe_op2_o, exe_imm_o;
  logic        id_stall_o;
  logic [CNT_BITS-1:0] lu_stall_cnt_o;

  id_exe_stage #(.CNT_BITS(CNT_BITS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .id_valid_i(id_valid_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_rd_addr_i(id_rd_addr_i), .id_reg_wr_i(id_reg_wr_i),
    .id_mem_rd_i(id_mem_rd_i), .stall_ext_i(stall_ext_i), .flush_i(flush_i),
    .forward_rs1_i(forward_rs1_i), .forward_rs2_i(forward_rs2_i),
    .mem_fwd_data_i(mem_fwd_data_i), .wb_reg_wr_i(wb_reg_wr_i),
    .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_data_i(wb_rd_data_i),
    .exe_valid_o(exe_valid_o), .exe_rs1_addr_o(exe_rs1_addr_o),
    .exe_rs2_addr_o(exe_rs2_addr_o), .exe_rd_addr_o(exe_rd_addr_o),
    .exe_reg_wr_o(exe_reg_wr_o), .exe_mem_rd_o(exe_mem_rd_o),
    .exe_op1_o(exe_op1_o), .exe_op2_o(exe_op2_o), .exe_imm_o(exe_imm_o),
    .id_stall_o(id_stall_o), .lu_stall_cnt_o(lu_stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one decoded instruction to ID.
  task automatic apply_stimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] imm, input logic [4:0] rd,
                                input logic wr, input logic mr);
    id_valid_i = v;  id_rs1_addr_i = rs1; id_rs2_addr_i = rs2;
    id_use_rs1_i = u1; id_use_rs2_i = u2; id_rs1_data_i = d1; id_rs2_data_i = d2;
    id_imm_i = imm; id_rd_addr_i = rd; id_reg_wr_i = wr; id_mem_rd_i = mr;
    #1;
  endtask

  task automatic push_exp(input string n, input logic v, input logic [4:0] rd,
                          input logic mr, input logic [31:0] o1, input logic [31:0] o2,
                          input logic [31:0] imm);
    exp_t x;
    x.name = n; x.valid = v; x.rd = rd; x.mem_rd = mr; x.op1 = o1; x.op2 = o2; x.imm = imm;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    apply_stimulus(1, 5'd1, 5'd2, 1, 1, 32'h100, 32'h200, 32'h10, 5'd3, 1, 0);
    tick(); tick();
    total++; if (exe_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0b want=0", exe_valid_o); end
    total++; if (exe_rd_addr_o !== 5'd0) begin bad++; $display("[TB] FAIL reset_rd got=%0d want=0", exe_rd_addr_o); end
    total++; if (exe_op1_o !== 32'd0 || exe_op2_o !== 32'd0 || exe_imm_o !== 32'd0) begin
      bad++; $display("[TB] FAIL reset_data got=%h/%h/%h want=0", exe_op1_o, exe_op2_o, exe_imm_o); end
    total++; if (lu_stall_cnt_o !== '0 || id_stall_o !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_cnt got=%0d stall=%0b want=0", lu_stall_cnt_o, id_stall_o); end
    rst_ni = 1'b1;
    push_exp("release", 1, 5'd3, 0, 32'h100, 32'h200, 32'h10);
    tick();
    e = sb.pop_front();
    total++; if (exe_valid_o !== e.valid || exe_rd_addr_o !== e.rd) begin
      bad++; $display("[TB] FAIL %s got v=%0b rd=%0d want v=%0b rd=%0d", e.name, exe_valid_o, exe_rd_addr_o, e.valid, e.rd); end
    total++; if (exe_op1_o !== e.op1 || exe_imm_o !== e.imm) begin
      bad++; $display("[TB] FAIL %s_data got=%h/%h want=%h/%h", e.name, exe_op1_o, exe_imm_o, e.op1, e.imm); end
  endtask

  task automatic test_load_use();
    apply_stimulus(1, 5'd2, 5'd0, 1, 0, 32'h40, 32'h0, 32'h4, 5'd5, 1, 1);
    push_exp("lw", 1, 5'd5, 1, 32'h40, 32'h0, 32'h4);
    tick();
    e = sb.pop_front();
    total++; if (exe_valid_o !== e.valid || exe_rd_addr_o !== e.rd || exe_mem_rd_o !== e.mem_rd) begin
      bad++; $display("[TB] FAIL %s got v=%0b rd=%0d mr=%0b", e.name, exe_valid_o, exe_rd_addr_o, exe_mem_rd_o); end
    apply_stimulus(1, 5'd5, 5'd1, 1, 1, 32'h0, 32'h11, 32'h0, 5'd6, 1, 0);
    total++; if (id_stall_o !== 1'b1) begin bad++; $display("[TB] FAIL lu_stall got=%0b want=1", id_stall_o); end
    exp_cnt++;
    push_exp("lu_bubble", 0, 5'd0, 0, 32'h0, 32'h0, 32'h0);
    tick();
    e = sb.pop_front();
    total++; if (exe_valid_o !== e.valid || exe_rd_addr_o !== e.rd || exe_mem_rd_o !== e.mem_rd) begin
      bad++; $display("[TB] FAIL %s got v=%0b rd=%0d mr=%0b want 0", e.name, exe_valid_o, exe_rd_addr_o, exe_mem_rd_o); end
    total++; if (id_stall_o !== 1'b0) begin bad++; $display("[TB] FAIL lu_release got=%0b want=0", id_stall_o); end
    push_exp("add", 1, 5'd6, 0, 32'h0, 32'h11, 32'h0);
    tick();
    e = sb.pop_front();
    total++; if (exe_valid_o !== e.valid || exe_rd_addr_o !== e.rd || exe_op2_o !== e.op2) begin
      bad++; $display("[TB] FAIL %s got v=%0b rd=%0d op2=%h want v=1 rd=%0d op2=%h", e.name, exe_valid_o, exe_rd_addr_o, exe_op2_o, e.rd, e.op2); end
    total++; if (lu_stall_cnt_o !== exp_cnt) begin bad++; $display("[TB] FAIL lu_cnt got=%0d want=%0d", lu_stall_cnt_o, exp_cnt); end
  endtask

  task automatic test_no_false_stall();
    apply_stimulus(1, 5'd2, 5'd0, 1, 0, 32'h0, 32'h0, 32'h0, 5'd0, 1, 1);
    tick();
    apply_stimulus(1, 5'd0, 5'd0, 1, 1, 32'h0, 32'h0, 32'h0, 5'd4, 1, 0);
    total++; if (id_stall_o !== 1'b0) begin bad++; $display("[TB] FAIL x0_load_stall got=%0b want=0", id_stall_o); end
    apply_stimulus(1, 5'd2, 5'd0, 1, 0, 32'h0, 32'h0, 32'h0, 5'd9, 1, 1);
    tick();
    apply_stimulus(1, 5'd3, 5'd9, 1, 0, 32'h0, 32'h0, 32'h0, 5'd4, 1, 0);
    total++; if (id_stall_o !== 1'b0) begin bad++; $display("[TB] FAIL unused_rs2_stall got=%0b want=0", id_stall_o); end
    apply_stimulus(1, 5'd3, 5'd9, 1, 1, 32'h0, 32'h0, 32'h0, 5'd4, 1, 0);
    total++; if (id_stall_o !== 1'b1) begin bad++; $display("[TB] FAIL used_rs2_stall got=%0b want=1", id_stall_o); end
    apply_stimulus(0, 5'd0, 5'd0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0);
    tick();
  endtask

  task automatic test_forward_mux();
    apply_stimulus(1, 5'd10, 5'd11, 1, 1, 32'h1111, 32'h2222, 32'h0, 5'd12, 1, 0);
    push_exp("fwd_base", 1, 5'd12, 0, 32'h1111, 32'h2222, 32'h0);
    tick();
    e = sb.pop_front();
    total++; if (exe_op1_o !== e.op1 || exe_op2_o !== e.op2) begin
      bad++; $display("[TB] FAIL %s got=%h/%h want=%h/%h", e.name, exe_op1_o, exe_op2_o, e.op1, e.op2); end
    forward_rs1_i = 2'd1; mem_fwd_data_i = 32'hAAAA_0001;
    forward_rs2_i = 2'd2; wb_rd_data_i = 32'h1234;
    #1;
    total++; if (exe_op1_o !== 32'hAAAA_0001) begin bad++; $display("[TB] FAIL fwd_mem got=%h want=aaaa0001", exe_op1_o); end
    total++; if (exe_op2_o !== 32'h1234) begin bad++; $display("[TB] FAIL fwd_wb got=%h want=00001234", exe_op2_o); end
    forward_rs1_i = 2'd3; forward_rs2_i = 2'd3;
    #1;
    total++; if (exe_op1_o !== e.op1 || exe_op2_o !== e.op2) begin
      bad++; $display("[TB] FAIL fwd_sel3 got=%h/%h want=%h/%h", exe_op1_o, exe_op2_o, e.op1, e.op2); end
    forward_rs1_i = 2'd0; forward_rs2_i = 2'd0; mem_fwd_data_i = '0; wb_rd_data_i = '0;
  endtask

  task automatic test_wb_bypass();
    wb_reg_wr_i = 1'b1; wb_rd_addr_i = 5'd7; wb_rd_data_i = 32'hDEAD;
    apply_stimulus(1, 5'd7, 5'd8, 1, 1, 32'h0, 32'h55, 32'h0, 5'd13, 1, 0);
    push_exp("wb_bypass", 1, 5'd13, 0, 32'hDEAD, 32'h55, 32'h0);
    tick();
    wb_reg_wr_i = 1'b0; wb_rd_data_i = 32'h0; #1;
    e = sb.pop_front();
    total++; if (exe_op1_o !== e.op1 || exe_op2_o !== e.op2) begin
      bad++; $display("[TB] FAIL %s got=%h/%h want=%h/%h", e.name, exe_op1_o, exe_op2_o, e.op1, e.op2); end
    wb_reg_wr_i = 1'b1; wb_rd_addr_i = 5'd0; wb_rd_data_i = 32'hBEEF;
    apply_stimulus(1, 5'd0, 5'd8, 1, 1, 32'h0, 32'h66, 32'h0, 5'd13, 1, 0);
    push_exp("wb_x0", 1, 5'd13, 0, 32'h0, 32'h66, 32'h0);
    tick();
    wb_reg_wr_i = 1'b0; wb_rd_data_i = 32'h0; #1;
    e = sb.pop_front();
    total++; if (exe_op1_o !== e.op1 || exe_op2_o !== e.op2) begin
      bad++; $display("[TB] FAIL %s got=%h/%h want=%h/%h", e.name, exe_op1_o, exe_op2_o, e.op1, e.op2); end
  endtask

  task automatic test_flush_stall();
    apply_stimulus(1, 5'd1, 5'd2, 1, 1, 32'hA0, 32'hA1, 32'h0, 5'd10, 1, 0);
    tick();
    apply_stimulus(1, 5'd1, 5'd2, 1, 1, 32'hB0, 32'hB1, 32'h0, 5'd11, 1, 0);
    stall_ext_i = 1'b1; flush_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_exp($sformatf("freeze%0d", i), 1, 5'd10, 0, 32'hA0, 32'hA1, 32'h0);
      tick();
      flush_i = 1'b0; #1;
      e = sb.pop_front();
      total++; if (exe_valid_o !== e.valid || exe_rd_addr_o !== e.rd || exe_op1_o !== e.op1) begin
        bad++; $display("[TB] FAIL %s got v=%0b rd=%0d op1=%h want v=1 rd=%0d op1=%h", e.name, exe_valid_o, exe_rd_addr_o, exe_op1_o, e.rd, e.op1); end
    end
    stall_ext_i = 1'b0; #1;
    push_exp("pend_bubble", 0, 5'd0, 0, 32'h0, 32'h0, 32'h0);
    tick();
    e = sb.pop_front();
    total++; if (exe_valid_o !== e.valid || exe_rd_addr_o !== e.rd) begin
      bad++; $display("[TB] FAIL %s got v=%0b rd=%0d want v=0 rd=0", e.name, exe_valid_o, exe_rd_addr_o); end
    push_exp("after_pend", 1, 5'd11, 0, 32'hB0, 32'hB1, 32'h0);
    tick();
    e = sb.pop_front();
    total++; if (exe_valid_o !== e.valid || exe_rd_addr_o !== e.rd || exe_op1_o !== e.op1) begin
      bad++; $display("[TB] FAIL %s got v=%0b rd=%0d op1=%h want v=1 rd=%0d op1=%h", e.name, exe_valid_o, exe_rd_addr_o, exe_op1_o, e.rd, e.op1); end
    flush_i = 1'b1;
    apply_stimulus(1, 5'd1, 5'd2, 1, 1, 32'hC0, 32'hC1, 32'h0, 5'd12, 1, 0);
    push_exp("direct_flush", 0, 5'd0, 0, 32'h0, 32'h0, 32'h0);
    tick();
    flush_i = 1'b0; #1;
    e = sb.pop_front();
    total++; if (exe_valid_o !== e.valid || exe_rd_addr_o !== e.rd) begin
      bad++; $display("[TB] FAIL %s got v=%0b rd=%0d want v=0 rd=0", e.name, exe_valid_o, exe_rd_addr_o); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    for (int i = 0; i < 8; i++) begin
      rs1 = 5'($urandom_range(1, 31)); rs2 = 5'($urandom_range(1, 31));
      rd = 5'($urandom_range(1, 31));
      d1 = $urandom; d2 = $urandom; imm = $urandom;
      apply_stimulus(1, rs1, rs2, 1, 1, d1, d2, imm, rd, 1, 0);
      push_exp($sformatf("b2b%0d", i), 1, rd, 0, d1, d2, imm);
      tick();
      e = sb.pop_front();
      total++; if (exe_valid_o !== e.valid || exe_rd_addr_o !== e.rd || exe_op1_o !== e.op1 ||
                   exe_op2_o !== e.op2 || exe_imm_o !== e.imm) begin
        bad++; $display("[TB] FAIL %s got v=%0b rd=%0d %h/%h/%h want rd=%0d %h/%h/%h", e.name, exe_valid_o,
                        exe_rd_addr_o, exe_op1_o, exe_op2_o, exe_imm_o, e.rd, e.op1, e.op2, e.imm); end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1, 5'd2, 5'd0, 1, 0, 32'h0, 32'h0, 32'h0, 5'd5, 1, 1);
      tick();
      apply_stimulus(1, 5'd1, 5'd5, 1, 1, 32'h0, 32'h0, 32'h0, 5'd6, 1, 0);
      if (exp_cnt != '1) exp_cnt++;
      tick();
      total++; if (lu_stall_cnt_o !== exp_cnt) begin
        bad++; $display("[TB] FAIL sat_cnt%0d got=%0d want=%0d", i, lu_stall_cnt_o, exp_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_forward_mux();
    test_wb_bypass();
    test_flush_stall();
    test_back_to_back();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
